mont_mult_arbiter: RTL and testbench
====================================

# mont_mult_arbiter

- Round-robin arbiter and sequencer that shares one `mont_final` Montgomery multiplier between up to `NUM_REQ` requesters.
- Sits between the point-arithmetic stage controllers (doubling, addition, scalar-mult steps) and a single multiplier instance, so several schedulers can issue multiplies without each owning a 256-bit multiplier.
- Per operation it:
  - latches one requester's operands,
  - pulses the multiplier start,
  - waits for completion,
  - returns the product on a shared result bus with a one-cycle, per-requester done pulse.

## Interface

Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 256, operand/modulus width

Ports:
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `i_req`  in  NUM_REQ  per-requester request level; held high until that requester's `o_done` bit pulses
- `i_req_A`  in  NUM_REQ*WIDTH  operand A, requester k at bits [k*WIDTH +: WIDTH]; stable while `i_req[k]` high
- `i_req_B`  in  NUM_REQ*WIDTH  operand B, same packing
- `i_p`  in  WIDTH  modulus, shared, stable during operation
- `o_grant`  out  NUM_REQ  one-hot owner of the multiplier; zero when idle
- `o_busy`  out  1  high from grant until done pulse inclusive
- `o_done`  out  NUM_REQ  one-cycle pulse on the owning requester's bit when `o_result` is valid
- `o_result`  out  WIDTH  last product; holds until next completion
- `o_mul_start`  out  1  one-cycle start to multiplier
- `o_mul_A`, `o_mul_B`, `o_mul_P`  out  WIDTH  registered operands; held from start until completion
- `i_mul_M`  in  WIDTH  multiplier result
- `i_mul_done`  in  1  multiplier done level; may still be high from the previous operation for one cycle after start

## Operation

- States:
  - **IDLE**
    - If any `i_req` is high: select the winner round-robin, register the one-hot grant, latch its A/B and `i_p` into `o_mul_*`, then go to ISSUE.
    - Otherwise stay in IDLE.
  - **ISSUE**: `o_mul_start`=1 for exactly this cycle; go to BLANK.
  - **BLANK**: ignore `i_mul_done` (covers stale done); go to WAIT.
  - **WAIT**: on `i_mul_done`=1, latch `i_mul_M` into `o_result` and go to RESP.
  - **RESP**: `o_done[g]`=1 for one cycle (g = granted index); clear grant; advance the round-robin pointer to g+1 mod `NUM_REQ`; go to IDLE.
- Round-robin rule:
  - The search starts at the pointer and takes the first high `i_req` bit in increasing index with wrap.
  - The pointer resets to 0, so requester 0 has initial priority.
- Requests are sampled only in IDLE. A request that rises mid-operation waits. A request that drops before grant is simply not selected.
- A requester that drops `i_req` while granted does not abort: the operation completes and `o_done` still pulses. A requester must not do this.
- No arithmetic is performed. All operand buses pass through at full `WIDTH` with no truncation.

## Timing

- Reset, synchronous and checked each rising edge with `i_rst_n`=0:
  - state → IDLE; pointer → 0;
  - `o_grant`, `o_busy`, `o_done`, `o_mul_start` → 0;
  - `o_result`, `o_mul_A`, `o_mul_B`, `o_mul_P` → 0.
- Reset mid-operation abandons the grant with no `o_done`. The multiplier is reset by the same signal.
- Request seen in IDLE at edge t:
  - grant/`o_busy`/operands valid after t;
  - `o_mul_start` high in cycle t+1;
  - BLANK in t+2;
  - WAIT from t+3.
- `i_mul_done` sampled high at edge d (in WAIT): `o_result`/`o_done` valid in cycle d+1; IDLE in d+2; the next grant can be registered at edge d+2.
- Minimum occupancy is 5 cycles plus multiplier latency. Back-to-back requests from different requesters incur one idle cycle.
- `o_busy` = (state ≠ IDLE).
- `o_mul_*` operands are held unchanged until the next grant.

## Test plan

- **Single request.** Mock multiplier: latency 10, done level, M = A·B mod P. Stimulus: req[2]=1, A=3, B=5, P=7. Required: grant=0100; one start pulse; `o_done`=0100 for one cycle; `o_result`=1; then idle.
- **Round-robin fairness.** Stimulus: req=1111 held, reissued after each done. Required: grant order 0,1,2,3,0,1 with no requester starved.
- **Stale done.** The mock holds done high until start and drops it one cycle after start. Required: the second operation's result is not taken from the first; exactly one `o_done` per grant.
- **Late request.** Stimulus: req[1] rises while requester 3 is in WAIT. Required: grant 1 is registered 2 cycles after `o_done`[3]. Operands for 3 are unchanged during its operation.
- **Reset mid-WAIT.** Stimulus: `i_rst_n`=0 for 1 cycle during WAIT. Required: all outputs 0 the next cycle; no `o_done`; pointer=0, so req=1010 grants 1 first.
- **Wrap-around.** Stimulus: only req[3], then only req[0]. Required: pointer wraps 3→0; both complete; `o_result` values match the mock.

Source files
------------

// File: rtl/mont_mult_arbiter_if.sv
// Request/response and multiplier-side bus of the shared Montgomery multiplier arbiter.
// slave is the arbiter's view; master is the requesters-plus-multiplier environment.
interface mont_mult_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 256
);
  logic [NUM_REQ-1:0]       i_req;
  logic [NUM_REQ*WIDTH-1:0] i_req_A;
  logic [NUM_REQ*WIDTH-1:0] i_req_B;
  logic [WIDTH-1:0]         i_p;
  logic [NUM_REQ-1:0]       o_grant;
  logic                     o_busy;
  logic [NUM_REQ-1:0]       o_done;
  logic [WIDTH-1:0]         o_result;
  logic                     o_mul_start;
  logic [WIDTH-1:0]         o_mul_A;
  logic [WIDTH-1:0]         o_mul_B;
  logic [WIDTH-1:0]         o_mul_P;
  logic [WIDTH-1:0]         i_mul_M;
  logic                     i_mul_done;

  modport slave (
    input  i_req, i_req_A, i_req_B, i_p, i_mul_M, i_mul_done,
    output o_grant, o_busy, o_done, o_result, o_mul_start, o_mul_A, o_mul_B, o_mul_P
  );

  modport master (
    output i_req, i_req_A, i_req_B, i_p, i_mul_M, i_mul_done,
    input  o_grant, o_busy, o_done, o_result, o_mul_start, o_mul_A, o_mul_B, o_mul_P
  );
endinterface

// File: rtl/mont_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one Montgomery multiplier between NUM_REQ requesters.
// Latches the winner's operands, pulses start, masks a stale done, returns the product with a done pulse.
module mont_mult_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  mont_mult_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IDX_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BLANK,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               busy_q;
  logic               start_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic [WIDTH-1:0]   mul_p_q;

  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic [PTR_W-1:0]   ptr_next;

  // First requesting index at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'(ptr) + IDX_W'(i);
      if (cand >= IDX_W'(NUM_REQ)) begin
        cand = cand - IDX_W'(NUM_REQ);
      end
      if (!win_valid && bus.i_req[cand[PTR_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign win_a = bus.i_req_A[32'(win_idx)*WIDTH +: WIDTH];
  assign win_b = bus.i_req_B[32'(win_idx)*WIDTH +: WIDTH];

  assign ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // Sequencer; every output is a register written here
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      mul_p_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            gnt_idx <= win_idx;
            grant_q <= NUM_REQ'(1) << win_idx;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            mul_a_q <= win_a;
            mul_b_q <= win_b;
            mul_p_q <= bus.i_p;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          state   <= S_BLANK;
        end
        // Multiplier done may still be high from the previous product here
        S_BLANK: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_mul_done) begin
            result_q <= bus.i_mul_M;
            done_q   <= grant_q;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr     <= ptr_next;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_result    = result_q;
  assign bus.o_mul_start = start_q;
  assign bus.o_mul_A     = mul_a_q;
  assign bus.o_mul_B     = mul_b_q;
  assign bus.o_mul_P     = mul_p_q;

  // Structural invariants of the grant/done/busy relationship
  a_grant_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(grant_q));
  a_busy_is_owned: assert property (@(posedge i_clk) disable iff (!i_rst_n) busy_q == (grant_q != '0));
  a_done_to_owner: assert property (@(posedge i_clk) disable iff (!i_rst_n) (done_q != '0) |-> (done_q == grant_q));
  a_start_in_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n) start_q |-> busy_q);

endmodule

// File: tb/tb_mont_mult_arbiter.sv
// Randomized bench for mont_mult_arbiter: mock multiplier with stale done, plus a
// transaction-level round-robin model that predicts grant order, operands and products.
module tb_mont_mult_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mont_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  mont_mult_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [NUM_REQ-1:0] req_mask;
  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];
  logic [WIDTH-1:0]   p_val;
  int                 lat;
  int                 rr;
  int                 obs_order [$];
  int                 n_checks = 0;
  int                 n_pass   = 0;

  always_comb begin
    bus.i_req   = req_mask;
    bus.i_p     = p_val;
    bus.i_req_A = '0;
    bus.i_req_B = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.i_req_A[k*WIDTH +: WIDTH] = a_arr[k];
      bus.i_req_B[k*WIDTH +: WIDTH] = b_arr[k];
    end
  end

  function automatic logic [WIDTH-1:0] modmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] p);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return WIDTH'(prod % {{WIDTH{1'b0}}, p});
  endfunction

  // Mock multiplier: done level stays high until one cycle after the next start
  logic [WIDTH-1:0] m_a, m_b, m_p;
  int               m_cnt;
  logic             m_run;
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.i_mul_done <= 1'b0;
      bus.i_mul_M    <= '0;
      m_run          <= 1'b0;
      m_cnt          <= 0;
    end else if (bus.o_mul_start) begin
      m_run <= 1'b1;
      m_cnt <= lat;
      m_a   <= bus.o_mul_A;
      m_b   <= bus.o_mul_B;
      m_p   <= bus.o_mul_P;
    end else if (m_run) begin
      if (m_cnt == 0) begin
        bus.i_mul_done <= 1'b1;
        bus.i_mul_M    <= modmul(m_a, m_b, m_p);
        m_run          <= 1'b0;
      end else begin
        bus.i_mul_done <= 1'b0;
        m_cnt          <= m_cnt - 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WIDTH-1:0] rand_w();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] onehot(input int idx);
    logic [WIDTH-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic int grant_index(input logic [NUM_REQ-1:0] g);
    int r;
    r = -1;
    for (int k = 0; k < NUM_REQ; k++) if (g[k]) r = k;
    return r;
  endfunction

  // Reference arbitration: first requester found scanning upward from rr with wrap
  function automatic int pick(input logic [NUM_REQ-1:0] mask, input int from);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[(from + i) % NUM_REQ]) return (from + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic new_operands(input int k);
    a_arr[k] = rand_w();
    b_arr[k] = rand_w();
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_grant"}, WIDTH'(bus.o_grant), '0);
    check_eq({pfx, "_busy"}, WIDTH'(bus.o_busy), '0);
    check_eq({pfx, "_done"}, WIDTH'(bus.o_done), '0);
    check_eq({pfx, "_start"}, WIDTH'(bus.o_mul_start), '0);
    check_eq({pfx, "_result"}, bus.o_result, '0);
    check_eq({pfx, "_mul_a"}, bus.o_mul_A, '0);
    check_eq({pfx, "_mul_b"}, bus.o_mul_B, '0);
    check_eq({pfx, "_mul_p"}, bus.o_mul_P, '0);
  endtask

  task automatic check_order(input string pfx, input int exp_q [$]);
    check_eq({pfx, "_count"}, WIDTH'(obs_order.size()), WIDTH'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_order.size(); i++)
      check_eq($sformatf("%s_%0d", pfx, i), WIDTH'(obs_order[i]), WIDTH'(exp_q[i]));
  endtask

  // Runs n_ops operations from the current negedge; the DUT ends idle one cycle after each done
  task automatic run_ops(input int n_ops, input bit reissue, input int late_bit,
                         input bit rand_mode, input int fixed_lat);
    int g, polls, wc;
    bit found, got, hold_ok;
    logic [WIDTH-1:0] ea, eb, ep, eres;
    for (int op = 0; op < n_ops; op++) begin
      if (rand_mode && req_mask == '0) begin
        int k;
        k = $urandom_range(0, NUM_REQ - 1);
        new_operands(k);
        req_mask[k] = 1'b1;
      end
      if (req_mask == '0) break;
      g    = pick(req_mask, rr);
      ea   = a_arr[g];
      eb   = b_arr[g];
      ep   = p_val;
      eres = modmul(ea, eb, ep);
      lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 12));

      found = 1'b0;
      polls = 0;
      for (int c = 1; c <= 8 && !found; c++) begin
        @(negedge clk);
        polls = c;
        if (bus.o_grant != '0) found = 1'b1;
      end
      check_eq("grant_seen", WIDTH'(found), WIDTH'(1));
      if (!found) return;
      check_eq("grant_latency", WIDTH'(polls), WIDTH'(1));
      check_eq("grant", WIDTH'(bus.o_grant), onehot(g));
      check_eq("busy_at_grant", WIDTH'(bus.o_busy), WIDTH'(1));
      check_eq("start_pulse", WIDTH'(bus.o_mul_start), WIDTH'(1));
      check_eq("mul_a", bus.o_mul_A, ea);
      check_eq("mul_b", bus.o_mul_B, eb);
      check_eq("mul_p", bus.o_mul_P, ep);
      obs_order.push_back(grant_index(bus.o_grant));

      got = 1'b0;
      hold_ok = 1'b1;
      wc = 0;
      for (int c = 1; c <= 60 && !got; c++) begin
        @(negedge clk);
        wc = c;
        if (bus.o_done != '0) begin
          got = 1'b1;
        end else begin
          if (bus.o_grant !== NUM_REQ'(onehot(g)) || bus.o_mul_start !== 1'b0 || bus.o_busy !== 1'b1 ||
              bus.o_mul_A !== ea || bus.o_mul_B !== eb || bus.o_mul_P !== ep)
            hold_ok = 1'b0;
          if (op == 0 && late_bit >= 0 && c == 3) begin
            new_operands(late_bit);
            req_mask[late_bit] = 1'b1;
          end
        end
      end
      check_eq("hold_during_op", WIDTH'(hold_ok), WIDTH'(1));
      check_eq("done_seen", WIDTH'(got), WIDTH'(1));
      if (!got) return;
      check_eq("done_latency", WIDTH'(wc), WIDTH'(lat + 3));
      check_eq("done", WIDTH'(bus.o_done), onehot(g));
      check_eq("result", bus.o_result, eres);
      check_eq("busy_in_resp", WIDTH'(bus.o_busy), WIDTH'(1));
      rr = (g + 1) % NUM_REQ;

      req_mask[g] = 1'b0;
      if (reissue || (rand_mode && $urandom_range(0, 1) == 1)) begin
        new_operands(g);
        req_mask[g] = 1'b1;
      end
      if (rand_mode) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!req_mask[k] && k != g && $urandom_range(0, 2) == 0) begin
            new_operands(k);
            req_mask[k] = 1'b1;
          end
        end
      end

      @(negedge clk);
      check_eq("done_one_cycle", WIDTH'(bus.o_done), '0);
      check_eq("idle_grant", WIDTH'(bus.o_grant), '0);
      check_eq("idle_busy", WIDTH'(bus.o_busy), '0);
      check_eq("result_held", bus.o_result, eres);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q [$];
    bit found, quiet;

    rst_n    = 1'b0;
    req_mask = '0;
    p_val    = '0;
    lat      = 4;
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = '0;
      b_arr[k] = '0;
    end
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    rr    = 0;

    // Single request from requester 2
    a_arr[2] = WIDTH'(3);
    b_arr[2] = WIDTH'(5);
    p_val    = WIDTH'(7);
    req_mask = 4'b0100;
    obs_order.delete();
    run_ops(1, 1'b0, -1, 1'b0, 10);
    req_mask = '0;
    check_eq("single_result", bus.o_result, WIDTH'(1));
    exp_q = '{2};
    check_order("single_order", exp_q);

    // Wrap-around 3 then 0, full-width operands
    p_val = rand_w() | {1'b1, {(WIDTH-1){1'b0}}} | WIDTH'(1);
    new_operands(3);
    req_mask = 4'b1000;
    obs_order.delete();
    run_ops(1, 1'b0, -1, 1'b0, 0);
    new_operands(0);
    req_mask = 4'b0001;
    run_ops(1, 1'b0, -1, 1'b0, 0);
    req_mask = '0;
    exp_q = '{3, 0};
    check_order("wrap_order", exp_q);

    // Late request from 1 while 3 waits
    new_operands(3);
    req_mask = 4'b1000;
    obs_order.delete();
    run_ops(2, 1'b0, 1, 1'b0, 0);
    req_mask = '0;
    exp_q = '{3, 1};
    check_order("late_order", exp_q);

    // Reset during WAIT abandons the operation and restores priority to 0
    new_operands(2);
    req_mask = 4'b0100;
    lat      = 20;
    found    = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (bus.o_grant != '0) found = 1'b1;
    end
    check_eq("rst_pre_grant", WIDTH'(bus.o_grant), onehot(2));
    repeat (5) @(negedge clk);
    rst_n    = 1'b0;
    req_mask = '0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    rr    = 0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_done != '0 || bus.o_busy != 1'b0) quiet = 1'b0;
    end
    check_eq("midrst_no_done", WIDTH'(quiet), WIDTH'(1));
    new_operands(1);
    new_operands(3);
    req_mask = 4'b1010;
    obs_order.delete();
    run_ops(2, 1'b0, -1, 1'b0, 0);
    req_mask = '0;
    exp_q = '{1, 3};
    check_order("midrst_order", exp_q);

    // Fairness with all four held and reissued
    for (int k = 0; k < NUM_REQ; k++) new_operands(k);
    req_mask = 4'b1111;
    obs_order.delete();
    run_ops(6, 1'b1, -1, 1'b0, 0);
    req_mask = '0;
    exp_q = '{0, 1, 2, 3, 0, 1};
    check_order("fair_order", exp_q);

    // Random traffic
    p_val = rand_w() | {1'b1, {(WIDTH-1){1'b0}}} | WIDTH'(1);
    run_ops(24, 1'b0, -1, 1'b1, 0);
    req_mask = '0;
    repeat (3) @(negedge clk);
    check_eq("final_idle", WIDTH'(bus.o_busy), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
